inst_fetch_queue: RTL and testbench

//  Decoupling FIFO directly downstream of the fetch stage, feeding decode.
//  - Captures each instruction and its PC+4 on cycles where the L1 instruction cache reports hit.
//  - Presents the oldest entry to decode with a valid/ready handshake.
//  - Back-pressures the PC register through fetchStall.
//  - Discards all contents on a taken branch (flush).

---
 rtl/inst_fetch_queue.sv | 97 +++++++++
 tb/tb_inst_fetch_queue.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// Show-ahead instruction FIFO between fetch and decode, with flush on taken branch.
// Optional same-cycle empty-queue bypass when FETCH_QUEUE_BYPASS_EN is defined.
module inst_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [WIDTH-1:0]         inst,
    input  logic [WIDTH-1:0]         pcOut,
    input  logic                     hit,
    input  logic                     flush,
    input  logic                     decodeReady,
    output logic [WIDTH-1:0]         instOut,
    output logic [WIDTH-1:0]         pcPlusFourOut,
    output logic                     instValid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     fetchStall
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] memInst [DEPTH];
    logic [WIDTH-1:0] memPc   [DEPTH];
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;

    logic notEmpty;
    logic bypass;
    logic pop;
    logic push;
    logic pushEn;

    assign notEmpty = (count != '0);

`ifdef FETCH_QUEUE_BYPASS_EN
    // Empty queue and decode ready: hand the fetched word straight through, never stored.
    assign bypass = ~notEmpty & hit & decodeReady & ~flush;
`else
    assign bypass = 1'b0;
`endif

    assign pop    = notEmpty & decodeReady;
    assign push   = hit & ((count < FULL) | pop) & ~bypass;
    assign pushEn = push & ~flush;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else if (flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is data only; it needs no reset because count gates visibility.
    always_ff @(posedge Clk) begin
        if (pushEn) begin
            memInst[wrPtr] <= inst;
            memPc[wrPtr]   <= pcOut;
        end
    end

    always_comb begin
        instValid     = notEmpty;
        instOut       = '0;
        pcPlusFourOut = '0;
        if (bypass) begin
            instValid     = 1'b1;
            instOut       = inst;
            pcPlusFourOut = pcOut;
        end else if (notEmpty) begin
            instOut       = memInst[rdPtr];
            pcPlusFourOut = memPc[rdPtr];
        end
    end

    assign fetchStall = (count == FULL);

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomized and directed bench for inst_fetch_queue against a queue-based reference model.
module tb_inst_fetch_queue;

    localparam int DEPTH = 4;
    localparam int WIDTH = 32;

    logic             Clk;
    logic             Reset;
    logic [WIDTH-1:0] inst;
    logic [WIDTH-1:0] pcOut;
    logic             hit;
    logic             flush;
    logic             decodeReady;
    logic [WIDTH-1:0] instOut;
    logic [WIDTH-1:0] pcPlusFourOut;
    logic             instValid;
    logic [$clog2(DEPTH):0] count;
    logic             fetchStall;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] refInst [$];
    logic [WIDTH-1:0] refPc   [$];

    inst_fetch_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .inst(inst),
        .pcOut(pcOut),
        .hit(hit),
        .flush(flush),
        .decodeReady(decodeReady),
        .instOut(instOut),
        .pcPlusFourOut(pcPlusFourOut),
        .instValid(instValid),
        .count(count),
        .fetchStall(fetchStall)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, check outputs at the falling edge, then advance the model.
    task automatic step(input string tag, input logic rst, input logic h, input logic f,
                        input logic dr, input logic [31:0] i, input logic [31:0] pc);
        bit expValid;
        bit doPop;
        bit doPush;
        bit byp;
        logic [31:0] expInst;
        logic [31:0] expPc;
        Reset = rst; hit = h; flush = f; decodeReady = dr; inst = i; pcOut = pc;
        @(negedge Clk);
        byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        byp = (refInst.size() == 0) && h && dr && !f;
`endif
        expValid = (refInst.size() != 0) || byp;
        expInst  = byp ? i  : (refInst.size() != 0 ? refInst[0] : 32'h0);
        expPc    = byp ? pc : (refPc.size()   != 0 ? refPc[0]   : 32'h0);
        chk({tag, ".instValid"}, {31'h0, instValid}, {31'h0, expValid});
        chk({tag, ".instOut"}, instOut, expInst);
        chk({tag, ".pcPlusFourOut"}, pcPlusFourOut, expPc);
        chk({tag, ".count"}, 32'(count), 32'(refInst.size()));
        chk({tag, ".fetchStall"}, {31'h0, fetchStall}, {31'h0, refInst.size() == DEPTH});
        if (rst || f) begin
            refInst.delete();
            refPc.delete();
        end else if (!byp) begin
            doPop  = (refInst.size() != 0) && dr;
            doPush = h && ((refInst.size() < DEPTH) || doPop);
            if (doPop) begin
                void'(refInst.pop_front());
                void'(refPc.pop_front());
            end
            if (doPush) begin
                refInst.push_back(i);
                refPc.push_back(pc);
            end
        end
        @(posedge Clk);
        #1;
    endtask

    initial begin
        logic [31:0] r;
        Reset = 1'b1; hit = 1'b0; flush = 1'b0; decodeReady = 1'b0; inst = '0; pcOut = '0;
        @(posedge Clk); #1;
        step("reset", 1, 0, 0, 0, 32'h0, 32'h0);
        step("idle", 0, 0, 0, 0, 32'h0, 32'h0);

        // Reset mid-traffic with three entries held.
        for (int k = 0; k < 3; k++)
            step("fill3", 0, 1, 0, 0, 32'h1000_0000 + k, 32'h0040_0004 + 4 * k);
        step("rst_mid", 1, 1, 0, 1, 32'hDEAD_0001, 32'h0);
        step("rst_mid", 1, 1, 0, 1, 32'hDEAD_0002, 32'h0);
        step("post_rst", 0, 0, 0, 0, 32'h0, 32'h0);

        // Fill to full with one extra dropped push, then drain in order.
        for (int k = 1; k <= 5; k++)
            step("full", 0, 1, 0, 0, 32'h2008_0000 + k, 32'h0040_0000 + 4 * k);
        step("full_hold", 0, 0, 0, 0, 32'h0, 32'h0);
        for (int k = 0; k < 5; k++)
            step("drain", 0, 0, 0, 1, 32'h0, 32'h0);

        // Simultaneous push and pop while full.
        for (int k = 0; k < 4; k++)
            step("refill", 0, 1, 0, 0, 32'h3000_0000 + k, 32'h0050_0000 + 4 * k);
        for (int k = 0; k < 3; k++)
            step("full_pp", 0, 1, 0, 1, 32'h3100_0000 + k, 32'h0051_0000 + 4 * k);
        for (int k = 0; k < 5; k++)
            step("drain2", 0, 0, 0, 1, 32'h0, 32'h0);

        // Flush wins over a same-cycle push.
        step("two", 0, 1, 0, 0, 32'h4000_0001, 32'h0060_0004);
        step("two", 0, 1, 0, 0, 32'h4000_0002, 32'h0060_0008);
        step("flush_hit", 0, 1, 1, 1, 32'h4000_0003, 32'h0060_000C);
        step("post_flush", 0, 0, 0, 0, 32'h0, 32'h0);

        // Push and pop at count==1.
        step("one", 0, 1, 0, 0, 32'h5000_0001, 32'h0070_0004);
        step("one_pp", 0, 1, 0, 1, 32'h5000_0002, 32'h0070_0008);
        step("one_pp", 0, 0, 0, 1, 32'h0, 32'h0);

`ifdef FETCH_QUEUE_BYPASS_EN
        step("bypass", 0, 1, 0, 1, 32'h8C09_0010, 32'h0080_0004);
        step("post_bypass", 0, 0, 0, 0, 32'h0, 32'h0);
`endif

        // Random traffic; pointers wrap many times, occasional flush.
        for (int k = 0; k < 300; k++) begin
            r = $urandom;
            step("rand", 0, r[0], (r[7:3] == 5'd0), r[1] | r[2], $urandom, $urandom & 32'hFFFF_FFFC);
        end
        for (int k = 0; k < 6; k++)
            step("final_drain", 0, 0, 0, 1, 32'h0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
